// File: rtl/uid_access_pkg.sv
// Shared types and constants for the UID access controller: FSM state encoding,
// the power-on authorised-UID table and the two reserved (never-matching) UIDs.
package uid_access_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_GRANT,
        ST_DENY,
        ST_LOCKOUT,
        ST_LEARN
    } state_t;

    localparam int TABLE_DEPTH = 16;
    localparam int TIMER_W     = 32;

    localparam logic [31:0] UID_NONE = 32'h0000_0000;
    localparam logic [31:0] UID_ALL  = 32'hFFFF_FFFF;

    // Entry 0 is the rightmost element. Slots 1 and 3 hold reserved values so
    // they can never grant until a learn cycle overwrites them.
    localparam logic [TABLE_DEPTH-1:0][31:0] DEFAULT_UIDS = {
        32'h1000_000F, 32'h1000_000E, 32'h1000_000D, 32'h1000_000C,
        32'h1000_000B, 32'h1000_000A, 32'h1000_0009, 32'h1000_0008,
        32'h1000_0007, 32'h1000_0006, 32'h1000_0005, 32'h1000_0004,
        32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0000_0000, 32'hA1B2_C3D4
    };

    function automatic logic uid_is_valid(input logic [31:0] uid);
        return (uid != UID_NONE) && (uid != UID_ALL);
    endfunction

endpackage

// File: rtl/uid_access_ctrl_hold_timer.sv
// Loadable down-counter; done is high while the count is zero, so loading N-1
// on state entry gives a state that lasts exactly N cycles.
module hold_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/uid_access_ctrl.sv
// RFID door controller: sequential UID table scan, grant/deny/lockout hold states.
// Define UID_LEARN_EN to enable runtime enrolment into the UID table.
module uid_access_ctrl
    import uid_access_pkg::*;
#(
    parameter int          NUM_UIDS     = 4,
    parameter int unsigned GRANT_CYCLES = 150_000_000,
    parameter int unsigned DENY_CYCLES  = 50_000_000,
    parameter int          MAX_FAIL     = 3,
    parameter int unsigned LOCK_CYCLES  = 500_000_000,
    parameter int unsigned LEARN_CYCLES = 500_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] UID,
    input  logic        card_OK,
    input  logic        learn_req,
    output logic        granted,
    output logic        denied,
    output logic        locked,
    output logic        relay,
    output logic        learned,
    output logic [31:0] last_uid,
    output logic [15:0] grant_cnt
);

`ifdef UID_LEARN_EN
    localparam bit LEARN_ON = 1'b1;
`else
    localparam bit LEARN_ON = 1'b0;
`endif

    localparam logic [3:0]        LAST_IDX   = 4'(NUM_UIDS - 1);
    localparam int                FAIL_W     = $clog2(MAX_FAIL + 1);
    localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAIL);

    state_t               state;
    state_t               state_next;
    logic                 card_q;
    logic                 card_evt;
    logic                 accept_evt;
    logic [3:0]           scan_idx;
    logic [31:0]          slot_uid;
    logic                 match;
    logic [FAIL_W-1:0]    fail_cnt;
    logic                 timer_load;
    logic [TIMER_W-1:0]   timer_val;
    logic                 timer_done;

    assign card_evt   = card_OK && !card_q;
    assign accept_evt = card_evt && ((state == ST_IDLE) || (LEARN_ON && state == ST_LEARN));
    assign match      = (state == ST_SCAN) && uid_is_valid(last_uid) && (slot_uid == last_uid);

`ifdef UID_LEARN_EN
    logic [31:0] table_q [TABLE_DEPTH];
    logic [3:0]  wr_ptr;
    logic        learned_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                table_q[i] <= DEFAULT_UIDS[i];
            end
            wr_ptr    <= '0;
            learned_q <= 1'b0;
        end else begin
            learned_q <= 1'b0;
            if (state == ST_LEARN && accept_evt && uid_is_valid(UID)) begin
                table_q[wr_ptr] <= UID;
                wr_ptr          <= (wr_ptr == LAST_IDX) ? 4'd0 : wr_ptr + 4'd1;
                learned_q       <= 1'b1;
            end
        end
    end

    assign slot_uid = table_q[scan_idx];
    assign learned  = learned_q;
`else
    assign slot_uid = DEFAULT_UIDS[scan_idx];
    assign learned  = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept_evt) begin
                    state_next = ST_SCAN;
                end else if (LEARN_ON && learn_req) begin
                    state_next = ST_LEARN;
                end
            end
            ST_SCAN: begin
                if (match) begin
                    state_next = ST_GRANT;
                end else if (scan_idx == LAST_IDX) begin
                    state_next = ST_DENY;
                end
            end
            ST_GRANT: begin
                if (timer_done) state_next = ST_IDLE;
            end
            ST_DENY: begin
                if (timer_done) state_next = (fail_cnt >= FAIL_LIMIT) ? ST_LOCKOUT : ST_IDLE;
            end
            ST_LOCKOUT: begin
                if (timer_done) state_next = ST_IDLE;
            end
            ST_LEARN: begin
                // Reserved UIDs are dropped silently; the learn window stays open.
                if ((accept_evt && uid_is_valid(UID)) || timer_done) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The timer reloads on every state change with the duration of the state entered.
    always_comb begin
        timer_load = (state_next != state);
        timer_val  = '0;
        case (state_next)
            ST_GRANT:   timer_val = TIMER_W'(GRANT_CYCLES - 1);
            ST_DENY:    timer_val = TIMER_W'(DENY_CYCLES - 1);
            ST_LOCKOUT: timer_val = TIMER_W'(LOCK_CYCLES - 1);
            ST_LEARN:   timer_val = TIMER_W'(LEARN_CYCLES - 1);
            default:    timer_val = '0;
        endcase
    end

    hold_timer #(
        .W (TIMER_W)
    ) u_hold_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            card_q    <= 1'b0;
            last_uid  <= '0;
            scan_idx  <= '0;
            grant_cnt <= '0;
            fail_cnt  <= '0;
        end else begin
            state  <= state_next;
            card_q <= card_OK;
            if (accept_evt) begin
                last_uid <= UID;
            end
            if (state == ST_IDLE) begin
                scan_idx <= '0;
            end else if (state == ST_SCAN) begin
                scan_idx <= scan_idx + 4'd1;
            end
            if (match) begin
                if (grant_cnt != 16'hFFFF) grant_cnt <= grant_cnt + 16'd1;
                fail_cnt <= '0;
            end else if (state == ST_SCAN && scan_idx == LAST_IDX) begin
                fail_cnt <= fail_cnt + FAIL_W'(1);
            end else if (state == ST_LOCKOUT && timer_done) begin
                fail_cnt <= '0;
            end
        end
    end

    assign granted = (state == ST_GRANT);
    assign relay   = (state == ST_GRANT);
    assign denied  = (state == ST_DENY);
    assign locked  = (state == ST_LOCKOUT);

endmodule
